multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: opcode  input  6  instruction opcode field from the instruction register.
REQ-004 SHALL have port: mem_ready  input  1  memory access complete this cycle.
REQ-005 SHALL have ports, all output, width 1: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA.
REQ-006 SHALL have ports, all output, width 2: ALUSrcB, PCSource, ALUOp; ALUOp feeds the existing ALUControl block.
REQ-007 SHALL have ports: illegal_op  output  1  one-cycle pulse for an unknown opcode; state  output  4  current state code.

Function
REQ-008 SHALL be a multicycle FSM with state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9.
REQ-009 SHALL decode opcodes: R-type=000000, LW=100011, SW=101011, BEQ=000100, J=000010.
REQ-010 SHALL drive every output not listed for a state to 0.
REQ-011 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, and IRWrite=PCWrite=mem_ready.
REQ-012 FETCH SHALL go to DECODE when mem_ready=1 and stay in FETCH otherwise.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and sample opcode.
REQ-014 DECODE SHALL go to MEMADR for LW/SW, EXEC for R-type, BRANCH for BEQ, JUMP for J.
REQ-015 For any other opcode, DECODE SHALL pulse illegal_op for that cycle and go to FETCH.
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, and go to MEMRD for LW or MEMWR for SW.
REQ-017 MEMRD SHALL drive MemRead=1, IorD=1, and go to MEMWB when mem_ready=1, holding otherwise.
REQ-018 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, and go to FETCH.
REQ-019 MEMWR SHALL hold MemWrite=1, IorD=1 until mem_ready=1, then go to FETCH.
REQ-020 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, and go to ALUWB.
REQ-021 ALUWB SHALL drive RegDst=1, RegWrite=1, MemtoReg=0, and go to FETCH.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, and go to FETCH.
REQ-023 JUMP SHALL drive PCWrite=1, PCSource=10, and go to FETCH.
REQ-024 State codes 10-15 SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-025 With mem_ready tied to 1, instruction latency SHALL be: R-type 4 cycles, LW 5, SW 4, BEQ 3, J 3.
REQ-026 Each memory wait cycle SHALL add exactly one cycle to that latency.
REQ-027 Outputs SHALL be combinational from state, plus opcode in DECODE and mem_ready in FETCH, MEMRD and MEMWR.

Reset
REQ-028 reset=1 at a rising edge SHALL set state to FETCH, taking priority over every transition, including mid-instruction and during memory waits.
REQ-029 While reset=1, all control outputs and illegal_op SHALL be forced to 0; state SHALL read 0 after the first reset edge.
REQ-030 In the first cycle after reset deasserts, the block SHALL be in FETCH with FETCH outputs active.

Structure
REQ-031 State codes, opcode constants and ALUOp codes (00 add, 01 sub, 10 funct) SHALL live in the shared package cpu_defs.
REQ-032 The block SHALL be a single module with no sub-module: one state register, next-state logic and output decode.

Verification
REQ-033 Reset held 2 cycles mid-MEMRD -> state=0, all outputs 0; after release, FETCH with MemRead=1.
REQ-034 opcode=000000, mem_ready=1 -> states 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1 and RegDst=1 in ALUWB.
REQ-035 opcode=100011, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemtoReg=1 in MEMWB.
REQ-036 opcode=101011, mem_ready=0 for first FETCH cycle -> FETCH held one cycle with IRWrite=0; MemWrite=1 in MEMWR; back to FETCH.
REQ-037 opcode=000100 -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01; opcode=000010 -> JUMP with PCWrite=1, PCSource=10.
REQ-038 opcode=111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle CPU control path: state codes,
// opcode constants, ALUOp codes and the control-word bundle.
package cpu_defs;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp encoding understood by the downstream ALUControl block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM. Moore-style control word per state,
// with opcode feeding DECODE and mem_ready feeding the memory states.
//
// state  | meaning
// FETCH  | read instruction, PC+4 on mem_ready
// DECODE | register read, branch target compute, dispatch on opcode
// MEMADR | effective address for LW/SW
// MEMRD  | data memory read, wait for mem_ready
// MEMWB  | write loaded word to register file
// MEMWR  | data memory write, wait for mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | BEQ compare and conditional PC update
// JUMP   | unconditional PC update
module multicycle_control
  import cpu_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  ctrl_t      ctrl;

  // State register; opcode captured in DECODE so MEMADR can pick LW vs SW
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode; everything defaults low and reset forces the word to zero
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = 2'b11;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~is_known_op(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = 2'b00;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      default: ctrl = '0;
    endcase
    if (reset) begin
      ctrl = '0;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign illegal_op  = ctrl.illegal_op;
  assign state       = state_q;

endmodule
